trigger_capture_unit: RTL and testbench

TRIGGER_CAPTURE_UNIT -- requirements
Module: trigger_capture_unit

---
 rtl/trigger_capture_unit.sv | 179 +++++++++++++++++
 tb/tb_trigger_capture_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_capture_unit.sv
// -----------------------------------------------------------------------------
// trigger_capture_unit
//
// Logic-analyzer style capture engine. After an arm it samples the 16 probe
// channels once every PRESCALING_FACTOR clocks. Each sample is written into an
// external ring buffer of 2^DEPTH_LOG2 words. Sampling continues until a
// per-channel edge trigger fires. Then POST_SAMPLES more samples are written
// and the block parks in DONE. TRIG_ADDR keeps the ring address of the
// trigger sample.
//
// Ports
//   clk, rst           single clock, asynchronous active-high reset
//   probe[15:0]        channel inputs, already synchronous to clk
//   PRESCALING_FACTOR  sample period in clocks (0 behaves as 1), latched on arm
//   TRIGGER_KIND[31:0] channel i kind in bits [2i+1:2i]:
//                      00 none, 01 rising, 10 falling, 11 either; latched on arm
//   arm, abort         level-sampled controls; abort wins over arm
//   mem_we/addr/data   write port to the sample RAM
//   BUSY               high in ARMED or CAPTURE
//   TRIGGERED          one-cycle pulse together with the trigger sample write
//   DONE               level, high in DONE
//   TRIG_ADDR          ring address of the trigger sample
//   dbg_state          current FSM state (IDLE=0, ARMED=1, CAPTURE=2, DONE=3)
//
// Handshake: mem_we is a one-cycle fire-and-forget strobe. The RAM must accept
// the word in the cycle mem_we is high. There is no ready or backpressure.
// -----------------------------------------------------------------------------
module trigger_capture_unit #(
  parameter int DEPTH_LOG2   = 10,
  parameter int POST_SAMPLES = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           probe,
  input  logic [15:0]           PRESCALING_FACTOR,
  input  logic [31:0]           TRIGGER_KIND,
  input  logic                  arm,
  input  logic                  abort,
  output logic                  mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [15:0]           mem_data,
  output logic                  BUSY,
  output logic                  TRIGGERED,
  output logic                  DONE,
  output logic [DEPTH_LOG2-1:0] TRIG_ADDR,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [DEPTH_LOG2-1:0] POST_INIT = DEPTH_LOG2'(POST_SAMPLES);

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q;
  logic [15:0]             presc_cnt_q;
  logic [15:0]             factor_q;
  logic [31:0]             kind_q;
  logic [15:0]             prev_q;
  logic                    prev_valid_q;
  logic [DEPTH_LOG2-1:0]   post_cnt_q;

  logic                    start_arm;
  logic                    post_open;
  logic                    strobe;
  logic                    do_write;
  logic [15:0]             hit_vec;
  logic                    trig;
  logic                    trig_take;

  // Control decode
  always_comb begin
    start_arm = ((state_q == S_IDLE) || (state_q == S_DONE)) && arm && !abort;
    // The post counter reaches 0 with the last post-trigger write. From then
    // on CAPTURE only waits one cycle before moving to DONE.
    post_open = (post_cnt_q != '0);
    strobe    = ((state_q == S_ARMED) || ((state_q == S_CAPTURE) && post_open))
                && (presc_cnt_q == 16'd0);
    do_write  = strobe && !abort;
  end

  // Per-channel edge detection between consecutive strobed samples
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < 16; i++) begin
      case (kind_q[2*i +: 2])
        2'b01:   hit_vec[i] = !prev_q[i] &&  probe[i];
        2'b10:   hit_vec[i] =  prev_q[i] && !probe[i];
        2'b11:   hit_vec[i] =  prev_q[i] !=  probe[i];
        default: hit_vec[i] = 1'b0;
      endcase
    end
    // The first sample after arm has no predecessor. It can only trigger in
    // free-run mode, when every channel kind is 00.
    trig      = strobe && (state_q == S_ARMED) &&
                (prev_valid_q ? (hit_vec != '0) : (kind_q == '0));
    trig_take = trig && !abort;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:    if (arm) state_d = S_ARMED;
        S_DONE:    if (arm) state_d = S_ARMED;
        S_ARMED:   if (trig_take) state_d = S_CAPTURE;
        S_CAPTURE: if (!post_open) state_d = S_DONE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      presc_cnt_q  <= '0;
      factor_q     <= '0;
      kind_q       <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      post_cnt_q   <= '0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      TRIGGERED    <= 1'b0;
      TRIG_ADDR    <= '0;
    end else begin
      mem_we    <= do_write;
      TRIGGERED <= trig_take;
      if (do_write) begin
        mem_addr <= wr_ptr_q;
        mem_data <= probe;
      end

      if (start_arm) begin
        wr_ptr_q     <= '0;
        presc_cnt_q  <= '0;           // strobe on the first clock in ARMED
        prev_valid_q <= 1'b0;
        factor_q     <= (PRESCALING_FACTOR == 16'd0) ? 16'd1 : PRESCALING_FACTOR;
        kind_q       <= TRIGGER_KIND;
      end else if ((state_q == S_ARMED) || (state_q == S_CAPTURE)) begin
        if (strobe) begin
          presc_cnt_q  <= factor_q - 16'd1;
          wr_ptr_q     <= wr_ptr_q + DEPTH_LOG2'(1);
          prev_q       <= probe;
          prev_valid_q <= 1'b1;
        end else begin
          presc_cnt_q  <= presc_cnt_q - 16'd1;
        end

        if (trig_take) begin
          TRIG_ADDR  <= wr_ptr_q;
          post_cnt_q <= POST_INIT;
        end else if (strobe && (state_q == S_CAPTURE)) begin
          post_cnt_q <= post_cnt_q - DEPTH_LOG2'(1);
        end
      end
    end
  end

  assign BUSY      = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign DONE      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_trigger_capture_unit.sv
// -----------------------------------------------------------------------------
// tb_trigger_capture_unit
//
// Bench for trigger_capture_unit with DEPTH_LOG2=3 and POST_SAMPLES=4.
// The reference model describes an acquisition in terms of sample indices.
// Sample k is taken m_t cycles after entry when m_t % factor == 0. It lands
// at ring address k mod 8. The trigger is the first sample with a qualifying
// edge. Writes stop after the sample with index trigger+POST.
// Directed scenarios add literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_trigger_capture_unit;
  localparam int D     = 3;
  localparam int DEPTH = 8;
  localparam int POST  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk, rst;
  logic [15:0]   probe, PRESCALING_FACTOR;
  logic [31:0]   TRIGGER_KIND;
  logic          arm, abort;
  logic          mem_we;
  logic [D-1:0]  mem_addr;
  logic [15:0]   mem_data;
  logic          BUSY, TRIGGERED, DONE;
  logic [D-1:0]  TRIG_ADDR;
  logic [1:0]    dbg_state;

  trigger_capture_unit #(.DEPTH_LOG2(D), .POST_SAMPLES(POST)) dut (
    .clk(clk), .rst(rst), .probe(probe),
    .PRESCALING_FACTOR(PRESCALING_FACTOR), .TRIGGER_KIND(TRIGGER_KIND),
    .arm(arm), .abort(abort),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .BUSY(BUSY), .TRIGGERED(TRIGGERED), .DONE(DONE),
    .TRIG_ADDR(TRIG_ADDR), .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  int            m_phase;          // 0 idle, 1 armed, 2 capture, 3 done
  int            m_t, m_k, m_f, m_trig_k;
  logic [31:0]   m_kind;
  logic [15:0]   m_prev;
  bit            m_have_prev;
  logic          e_we, e_trig;
  logic [D-1:0]  e_taddr;
  logic [D+15:0] exp_q[$];         // {addr, data} of expected writes

  // observation of DUT behaviour for the directed literal checks
  int            o_writes, o_trigs, o_last_we_cyc, o_done_cyc, o_min_gap, o_max_gap;
  logic [D-1:0]  o_last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected completion (cycle %0d)", name, cyc);
  endtask

  function automatic bit chan_hit(input logic [1:0] kind, input logic a, input logic b);
    case (kind)
      2'b01:   return !a && b;
      2'b10:   return a && !b;
      2'b11:   return a != b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_t = 0; m_k = 0; m_f = 1; m_trig_k = 0;
    m_kind = '0; m_prev = '0; m_have_prev = 0;
    e_we = 0; e_trig = 0; e_taddr = '0;
    exp_q.delete();
  endtask

  // Advance the model across one rising edge using the current inputs
  task automatic model_step();
    bit strobe, hit;
    strobe = 0;
    hit    = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (m_phase == 1 || (m_phase == 2 && m_k <= m_trig_k + POST))
        strobe = (m_t % m_f) == 0;
      if (strobe) begin
        if (!m_have_prev) hit = (m_kind == 0);
        else
          for (int ch = 0; ch < 16; ch++)
            if (chan_hit(m_kind[2*ch +: 2], m_prev[ch], probe[ch])) hit = 1;
      end
      e_we   = strobe && !abort;
      e_trig = e_we && (m_phase == 1) && hit;
      if (e_we)   exp_q.push_back({D'(m_k % DEPTH), probe});
      if (e_trig) e_taddr = D'(m_k % DEPTH);

      if (abort) begin
        m_phase = 0;
      end else if (m_phase == 0 || m_phase == 3) begin
        if (arm) begin
          m_phase = 1; m_t = 0; m_k = 0; m_have_prev = 0;
          m_f = (PRESCALING_FACTOR == 0) ? 1 : int'(PRESCALING_FACTOR);
          m_kind = TRIGGER_KIND;
        end
      end else begin
        if (m_phase == 2 && !strobe && m_k > m_trig_k + POST) m_phase = 3;
        if (strobe) begin
          if (m_phase == 1 && hit) begin
            m_trig_k = m_k;
            m_phase  = 2;
          end
          m_prev = probe; m_have_prev = 1; m_k++;
        end
        m_t++;
      end
    end
  endtask

  // ---------------- scoreboard compare (every cycle) ----------------
  task automatic compare();
    logic [D+15:0] w;
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_we && exp_q.size() > 0) begin
      w = exp_q.pop_front();
      if (mem_we === 1'b1) begin
        chk("mem_addr", 32'(mem_addr), 32'(w[D+15:16]));
        chk("mem_data", 32'(mem_data), 32'(w[15:0]));
      end
    end
    chk("TRIGGERED", 32'(TRIGGERED), 32'(e_trig));
    chk("TRIG_ADDR", 32'(TRIG_ADDR), 32'(e_taddr));
    chk("BUSY", 32'(BUSY), 32'(m_phase == 1 || m_phase == 2));
    chk("DONE", 32'(DONE), 32'(m_phase == 3));
    chk("dbg_state", 32'(dbg_state), 32'(m_phase));

    if (mem_we === 1'b1) begin
      if (o_last_we_cyc >= 0) begin
        if (cyc - o_last_we_cyc < o_min_gap) o_min_gap = cyc - o_last_we_cyc;
        if (cyc - o_last_we_cyc > o_max_gap) o_max_gap = cyc - o_last_we_cyc;
      end
      o_last_we_cyc = cyc;
      o_last_addr   = mem_addr;
      o_writes++;
    end
    if (TRIGGERED === 1'b1) o_trigs++;
    if (DONE === 1'b1 && o_done_cyc < 0) o_done_cyc = cyc;
  endtask

  task automatic clear_obs();
    o_writes = 0; o_trigs = 0; o_last_we_cyc = -1; o_done_cyc = -1;
    o_min_gap = 1000000; o_max_gap = 0; o_last_addr = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  task automatic arm_with(input logic [15:0] pf, input logic [31:0] tk);
    PRESCALING_FACTOR = pf;
    TRIGGER_KIND      = tk;
    clear_obs();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  function automatic logic [31:0] rand_kinds();
    logic [31:0] k;
    k = '0;
    for (int ch = 0; ch < 16; ch++)
      if ($urandom_range(0, 9) == 0) k[2*ch +: 2] = 2'($urandom_range(1, 3));
    return k;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0;
    probe = '0; PRESCALING_FACTOR = '0; TRIGGER_KIND = '0;
    model_reset();
    clear_obs();
    repeat (2) tick();
    chk("reset_mem_we", 32'(mem_we), 0);
    chk("reset_busy", 32'(BUSY), 0);
    chk("reset_done", 32'(DONE), 0);
    chk("reset_trig_addr", 32'(TRIG_ADDR), 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_after_reset", 32'(BUSY), 0);

    // A: factor 4, ch0 rising; probe[0] rises in time for sample 9
    arm_with(16'd4, 32'h0000_0001);
    for (int n = 0; n < 200 && DONE !== 1'b1; n++) begin
      probe[0] = (n >= 34);
      tick();
    end
    if (DONE !== 1'b1) timeout_fail("A_done");
    chk("A_trig_count", 32'(o_trigs), 1);
    chk("A_trig_addr", 32'(TRIG_ADDR), 1);
    chk("A_last_addr", 32'(o_last_addr), 5);
    chk("A_writes", 32'(o_writes), 14);
    chk("A_min_gap", 32'(o_min_gap), 4);
    chk("A_max_gap", 32'(o_max_gap), 4);
    chk("A_done_lag", 32'(o_done_cyc - o_last_we_cyc), 1);
    PRESCALING_FACTOR = 16'd7; TRIGGER_KIND = 32'hFFFF_FFFF;
    repeat (5) tick();
    chk("A_done_held", 32'(DONE), 1);
    chk("A_trig_addr_held", 32'(TRIG_ADDR), 1);

    // B: free-run, factor 0 behaves as 1
    arm_with(16'd0, 32'h0);
    for (int n = 0; n < 40 && DONE !== 1'b1; n++) begin
      probe = 16'($urandom);
      tick();
    end
    if (DONE !== 1'b1) timeout_fail("B_done");
    chk("B_trig_addr", 32'(TRIG_ADDR), 0);
    chk("B_writes", 32'(o_writes), 5);
    chk("B_last_addr", 32'(o_last_addr), 4);
    chk("B_max_gap", 32'(o_max_gap), 1);
    chk("B_done_lag", 32'(o_done_cyc - o_last_we_cyc), 1);

    // C: ch5 falling edge at sample 12, the ring wraps 7->0
    probe = 16'h0020;
    arm_with(16'd1, 32'h0000_0800);
    for (int n = 0; n < 60 && DONE !== 1'b1; n++) begin
      probe    = 16'($urandom);
      probe[5] = (n < 12);
      tick();
    end
    if (DONE !== 1'b1) timeout_fail("C_done");
    chk("C_trig_addr", 32'(TRIG_ADDR), 4);
    chk("C_writes", 32'(o_writes), 17);
    chk("C_last_addr", 32'(o_last_addr), 0);

    // F: asynchronous reset while ARMED
    probe = 16'hA5A5;
    arm_with(16'd2, 32'h0000_0001);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("F_rst_mem_we", 32'(mem_we), 0);
    chk("F_rst_busy", 32'(BUSY), 0);
    chk("F_rst_triggered", 32'(TRIGGERED), 0);
    chk("F_rst_done", 32'(DONE), 0);
    chk("F_rst_mem_addr", 32'(mem_addr), 0);
    chk("F_rst_mem_data", 32'(mem_data), 0);
    chk("F_rst_trig_addr", 32'(TRIG_ADDR), 0);
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    clear_obs();
    repeat (10) tick();
    chk("F_no_writes", 32'(o_writes), 0);
    chk("F_idle", 32'(BUSY), 0);

    // G: arm and abort together keep the block idle
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    chk("G_busy", 32'(BUSY), 0);
    chk("G_state", 32'(dbg_state), 0);
    clear_obs();
    repeat (3) tick();
    chk("G_no_writes", 32'(o_writes), 0);

    // D: one-clock pulse on ch2 between strobes of factor 8 is never seen
    probe = '0;
    arm_with(16'd8, 32'h0000_0030);
    for (int n = 0; n < 64; n++) begin
      probe[2] = (n % 8 == 3);
      tick();
    end
    chk("D_no_trigger", 32'(o_trigs), 0);
    chk("D_still_busy", 32'(BUSY), 1);
    chk("D_writes", 32'(o_writes), 8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("D_abort_idle", 32'(BUSY), 0);

    // E: abort on a strobe cycle during CAPTURE
    arm_with(16'd3, 32'h0);
    repeat (3) tick();
    chk("E_triggered", 32'(o_trigs), 1);
    chk("E_capture", 32'(dbg_state), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("E_abort_we", 32'(mem_we), 0);
    chk("E_abort_busy", 32'(BUSY), 0);
    chk("E_abort_done", 32'(DONE), 0);
    clear_obs();
    repeat (10) tick();
    chk("E_no_writes", 32'(o_writes), 0);

    // Randomized acquisitions against the model
    for (int it = 0; it < 25; it++) begin
      probe = 16'($urandom);
      arm_with(16'($urandom_range(0, 4)), rand_kinds());
      for (int n = 0; n < 150; n++) begin
        for (int b = 0; b < 16; b++)
          if ($urandom_range(0, 15) == 0) probe[b] = ~probe[b];
        PRESCALING_FACTOR = 16'($urandom_range(0, 4));
        TRIGGER_KIND      = rand_kinds();
        arm   = ($urandom_range(0, 19) == 0);
        abort = ($urandom_range(0, 199) == 0);
        tick();
      end
      arm = 1'b0; abort = 1'b0;
    end

    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
